dcache: RTL

Two-way set-associative, write-back, write-allocate data cache between the pipeline's MEM stage and the memory controller. It serves the datapath's data requests (dmemREN/dmemWEN/dmemaddr/dmemstore → dmemload/dhit) and fills or evicts 2-word blocks over the controller's dREN/dWEN/daddr/dstore/dload/dwait handshake. On halt it writes back every dirty frame, optionally stores a hit count, and then raises flushed.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/dcache_way.sv | 35 +++
 rtl/dcache.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data-cache address split, frame layout and block-address helper.
package cpu_types_pkg;

    localparam int DTAG_W = 26;
    localparam int DIDX_W = 3;
    localparam int DBLK_W = 1;
    localparam int DBYT_W = 2;

    typedef struct packed {
        logic [DTAG_W-1:0] tag;
        logic [DIDX_W-1:0] idx;
        logic [DBLK_W-1:0] blkoff;
        logic [DBYT_W-1:0] bytoff;
    } dcachef_t;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [DTAG_W-1:0] tag;
        logic [1:0][31:0]  word;
    } dcache_frame_t;

    function automatic logic [31:0] dblk_addr(input logic [DTAG_W-1:0] tag,
                                              input logic [DIDX_W-1:0] idx,
                                              input logic [DBLK_W-1:0] blk);
        return {tag, idx, blk, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the data cache: frame array with async clear, tag compare and word select.
module dcache_way
    import cpu_types_pkg::*;
#(
    parameter int SETS = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [DIDX_W-1:0]   idx_i,
    input  logic [DTAG_W-1:0]   tag_i,
    input  logic [DBLK_W-1:0]   blkoff_i,
    input  logic                we_i,
    input  dcache_frame_t       wframe_i,
    output logic                hit_o,
    output logic [31:0]         rdata_o,
    output dcache_frame_t       frame_o
);

    dcache_frame_t frames_q [SETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                frames_q[i] <= '0;
            end
        end else if (we_i) begin
            frames_q[idx_i] <= wframe_i;
        end
    end

    assign frame_o = frames_q[idx_i];
    assign hit_o   = frame_o.valid && (frame_o.tag == tag_i);
    assign rdata_o = frame_o.word[blkoff_i];

endmodule

// File: rtl/dcache.sv
// Two-way write-back, write-allocate data cache with LRU replacement and halt-time flush.
// Define DCACHE_HITCOUNT_EN to append a store of the hit count to HITCNT_ADDR after the flush.
module dcache
    import cpu_types_pkg::*;
#(
    parameter int          SETS        = 8,
    parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore
);

    if (SETS != (1 << DIDX_W) || HITCNT_ADDR[1:0] != 2'b00) begin : g_cfg_err
        $error("dcache: SETS must match DIDX_W and HITCNT_ADDR must be word aligned");
    end

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        LD0,
        LD1,
        FLUSH,
        FWB0,
        FWB1,
`ifdef DCACHE_HITCOUNT_EN
        HCNT,
`endif
        DONE
    } state_t;

`ifdef DCACHE_HITCOUNT_EN
    localparam state_t FLUSH_END = HCNT;
`else
    localparam state_t FLUSH_END = DONE;
`endif

    state_t              state_q;
    logic [DTAG_W-1:0]   miss_tag_q;
    logic [DIDX_W-1:0]   miss_idx_q;
    logic                victim_q;
    logic [SETS-1:0]     lru_q;
    logic [DIDX_W:0]     fidx_q;
    logic [31:0]         word0_q;
`ifdef DCACHE_HITCOUNT_EN
    logic [31:0]         hitcnt_q;
    logic                fill_hit_q;
`endif

    dcachef_t            req_a;
    logic [DIDX_W-1:0]   lk_idx;
    logic                flushing;
    logic                cur_way;
    dcache_frame_t       cur_frame;
    dcache_frame_t       miss_frame;
    logic                hit_any;
    logic                hit_way;
    logic                xfer_done;
    logic                last_frame;
    logic [1:0]          way_hit;
    logic [1:0]          way_we;
    logic [31:0]         way_rdata  [2];
    dcache_frame_t       way_frame  [2];
    dcache_frame_t       way_wframe [2];

    assign req_a      = dmemaddr;
    assign flushing   = (state_q == FLUSH) || (state_q == FWB0) || (state_q == FWB1);
    assign xfer_done  = !dwait;
    assign last_frame = &fidx_q;
    assign hit_any    = |way_hit;
    assign hit_way    = way_hit[1];

    // Halt wins over a same-cycle request; only IDLE serves the datapath.
    assign dhit     = (state_q == IDLE) && !halt && (dmemREN || dmemWEN) && hit_any;
    assign dmemload = dhit ? way_rdata[hit_way] : '0;
    assign flushed  = (state_q == DONE);

    always_comb begin
        lk_idx = miss_idx_q;
        if (state_q == IDLE) begin
            lk_idx = req_a.idx;
        end else if (flushing) begin
            lk_idx = fidx_q[DIDX_W:1];
        end
    end

    assign cur_way    = flushing ? fidx_q[0] : victim_q;
    assign cur_frame  = way_frame[cur_way];
    assign miss_frame = way_frame[lru_q[req_a.idx]];

    for (genvar w = 0; w < 2; w++) begin : g_way
        dcache_way #(.SETS(SETS)) u_way (
            .CLK      (CLK),
            .nRST     (nRST),
            .idx_i    (lk_idx),
            .tag_i    (req_a.tag),
            .blkoff_i (req_a.blkoff),
            .we_i     (way_we[w]),
            .wframe_i (way_wframe[w]),
            .hit_o    (way_hit[w]),
            .rdata_o  (way_rdata[w]),
            .frame_o  (way_frame[w])
        );
    end

    always_comb begin
        way_we        = '0;
        way_wframe[0] = way_frame[0];
        way_wframe[1] = way_frame[1];
        if (dhit && dmemWEN) begin
            way_we[hit_way]                          = 1'b1;
            way_wframe[hit_way].word[req_a.blkoff]   = dmemstore;
            way_wframe[hit_way].dirty                = 1'b1;
        end
        if (state_q == LD1 && xfer_done) begin
            way_we[victim_q]           = 1'b1;
            way_wframe[victim_q].valid = 1'b1;
            way_wframe[victim_q].dirty = 1'b0;
            way_wframe[victim_q].tag   = miss_tag_q;
            way_wframe[victim_q].word  = {dload, word0_q};
        end
        if (state_q == FWB1 && xfer_done) begin
            way_we[fidx_q[0]]           = 1'b1;
            way_wframe[fidx_q[0]].dirty = 1'b0;
        end
    end

    // Bus outputs decode straight from registered state, so they hold until dwait drops.
    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        case (state_q)
            WB0, FWB0: begin
                dWEN   = 1'b1;
                daddr  = dblk_addr(cur_frame.tag, lk_idx, 1'b0);
                dstore = cur_frame.word[0];
            end
            WB1, FWB1: begin
                dWEN   = 1'b1;
                daddr  = dblk_addr(cur_frame.tag, lk_idx, 1'b1);
                dstore = cur_frame.word[1];
            end
            LD0: begin
                dREN  = 1'b1;
                daddr = dblk_addr(miss_tag_q, miss_idx_q, 1'b0);
            end
            LD1: begin
                dREN  = 1'b1;
                daddr = dblk_addr(miss_tag_q, miss_idx_q, 1'b1);
            end
`ifdef DCACHE_HITCOUNT_EN
            HCNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = hitcnt_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            victim_q   <= 1'b0;
            lru_q      <= '0;
            fidx_q     <= '0;
            word0_q    <= '0;
`ifdef DCACHE_HITCOUNT_EN
            hitcnt_q   <= '0;
            fill_hit_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (halt) begin
                        state_q <= FLUSH;
                        fidx_q  <= '0;
                    end else if (dmemREN || dmemWEN) begin
                        if (hit_any) begin
                            lru_q[req_a.idx] <= ~hit_way;
                        end else begin
                            miss_tag_q <= req_a.tag;
                            miss_idx_q <= req_a.idx;
                            victim_q   <= lru_q[req_a.idx];
                            state_q    <= (miss_frame.valid && miss_frame.dirty) ? WB0 : LD0;
                        end
                    end
`ifdef DCACHE_HITCOUNT_EN
                    if (dhit) begin
                        if (fill_hit_q) begin
                            fill_hit_q <= 1'b0;
                        end else begin
                            hitcnt_q <= hitcnt_q + 32'd1;
                        end
                    end
`endif
                end
                WB0: if (xfer_done) state_q <= WB1;
                WB1: if (xfer_done) state_q <= LD0;
                LD0: begin
                    if (xfer_done) begin
                        word0_q <= dload;
                        state_q <= LD1;
                    end
                end
                LD1: begin
                    if (xfer_done) begin
                        state_q <= IDLE;
`ifdef DCACHE_HITCOUNT_EN
                        fill_hit_q <= 1'b1;
`endif
                    end
                end
                FLUSH: begin
                    if (cur_frame.valid && cur_frame.dirty) begin
                        state_q <= FWB0;
                    end else if (last_frame) begin
                        state_q <= FLUSH_END;
                    end else begin
                        fidx_q <= fidx_q + 1'b1;
                    end
                end
                FWB0: if (xfer_done) state_q <= FWB1;
                FWB1: begin
                    if (xfer_done) begin
                        if (last_frame) begin
                            state_q <= FLUSH_END;
                        end else begin
                            fidx_q  <= fidx_q + 1'b1;
                            state_q <= FLUSH;
                        end
                    end
                end
`ifdef DCACHE_HITCOUNT_EN
                HCNT: if (xfer_done) state_q <= DONE;
`endif
                DONE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
